// File: rtl/bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_ctrl
//
// Four-digit BCD stopwatch controller. A prescaler divides clk by TICK_DIV.
// Each prescaler wrap advances the BCD count by one. The count can be paused,
// resumed, cleared, lap-captured and stopped at a programmable BCD limit.
//
// Parameters
//   TICK_DIV    clk cycles per least-significant-digit increment (2..65535)
//
// Ports
//   clk         system clock, all state updates on posedge
//   rst         asynchronous active-low reset; release is synchronised to clk
//   start       level command: begin / resume counting
//   stop        level command: pause counting (wins over start)
//   clear       level command: back to IDLE with zero count (wins over all)
//   lap         level command: capture the current digits into lap_digits
//   limit[15:0] BCD target, [3:0] = units; 16'h0000 means no limit
//   digits      current BCD count, [3:0] = units
//   lap_digits  last captured count
//   running     high while the FSM is in RUN
//   done        high while the FSM is in DONE
// ---------------------------------------------------------------------------
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    input  logic [15:0] limit,
    output logic [15:0] digits,
    output logic [15:0] lap_digits,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t      state_reg;
    logic [15:0] prescale_reg;
    logic [15:0] digits_reg;
    logic [15:0] lap_reg;
    logic        running_reg;
    logic        done_reg;

    // Reset bridge: assertion is immediate, release takes two clk edges so
    // the FSM never sees a reset edge that is close to a clock edge.
    logic [1:0]  rst_sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    // Decimal ripple increment. A digit advances only when every digit
    // below it is 9; each digit wraps 9 -> 0, so 9999 wraps to 0000.
    logic [15:0] digits_next;
    logic [3:0]  carry;
    logic [3:0]  limit_nib_ok;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = digits_reg[gi*4 +: 4];
            assign digits_next[gi*4 +: 4] =
                carry[gi] ? ((nib == 4'd9) ? 4'd0 : nib + 4'd1) : nib;
            // Limit nibbles above 9 can never be reached by a BCD count.
            assign limit_nib_ok[gi] = (limit[gi*4 +: 4] <= 4'd9);
            if (gi < 3) begin : g_carry
                assign carry[gi+1] = carry[gi] & (nib == 4'd9);
            end
        end
    endgenerate

    // Compared against the value the count is about to take, so a tick that
    // reaches the limit moves to DONE on the same edge.
    logic limit_hit;
    assign limit_hit = (limit != 16'h0000) && (&limit_nib_ok) &&
                       (digits_next == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            prescale_reg <= 16'h0000;
            digits_reg   <= 16'h0000;
            lap_reg      <= 16'h0000;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else if (rst_sync_reg[1]) begin
            // Lap samples the pre-edge count, including on a clear edge.
            if (lap && (state_reg != IDLE)) begin
                lap_reg <= digits_reg;
            end

            if (clear) begin
                state_reg    <= IDLE;
                prescale_reg <= 16'h0000;
                digits_reg   <= 16'h0000;
                running_reg  <= 1'b0;
                done_reg     <= 1'b0;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        if (start && !stop) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            // Prescaler keeps its value so the interrupted
                            // interval finishes after resume.
                            state_reg   <= PAUSE;
                            running_reg <= 1'b0;
                        end else if (prescale_reg == TICK_LAST) begin
                            prescale_reg <= 16'h0000;
                            digits_reg   <= digits_next;
                            if (limit_hit) begin
                                state_reg   <= DONE;
                                running_reg <= 1'b0;
                                done_reg    <= 1'b1;
                            end
                        end else begin
                            prescale_reg <= prescale_reg + 16'd1;
                        end
                    end
                    PAUSE: begin
                        if (start && !stop) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end
                    end
                    DONE: begin
                        // Only clear or reset leaves DONE.
                    end
                    default: begin
                        state_reg   <= IDLE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign digits     = digits_reg;
    assign lap_digits = lap_reg;
    assign running    = running_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_stopwatch_ctrl
//
// Self-checking bench for bcd_stopwatch_ctrl with TICK_DIV = 2. A behavioural
// model keeps the count as a plain integer and converts it to BCD. Each cycle
// the expected outputs are pushed to a scoreboard queue before the edge. They
// are popped and compared after the edge. Directed checks against constants
// cover the main scenarios.
// ---------------------------------------------------------------------------
module tb_bcd_stopwatch_ctrl;

    localparam int TD = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        clear;
    logic        lap;
    logic [15:0] limit;
    logic [15:0] digits;
    logic [15:0] lap_digits;
    logic        running;
    logic        done;

    bcd_stopwatch_ctrl #(
        .TICK_DIV(TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .lap       (lap),
        .limit     (limit),
        .digits    (digits),
        .lap_digits(lap_digits),
        .running   (running),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] l;
        logic        r;
        logic        dn;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
    int m_st   = 0;
    int m_pre  = 0;
    int m_cnt  = 0;
    int m_lap  = 0;
    int m_rcnt = 0;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Decimal value of a BCD limit, or -1 when it can never match.
    function automatic int lim_val(input logic [15:0] l);
        int acc;
        logic [3:0] n;
        acc = 0;
        if (l == 16'h0000) return -1;
        for (int i = 3; i >= 0; i--) begin
            n = l[i*4 +: 4];
            if (n > 4'd9) return -1;
            acc = acc * 10 + int'(n);
        end
        return acc;
    endfunction

    task automatic model_reset();
        m_st = 0; m_pre = 0; m_cnt = 0; m_lap = 0; m_rcnt = 0;
    endtask

    task automatic model_next();
        if (!rst) begin
            model_reset();
        end else if (m_rcnt < 2) begin
            m_rcnt++;
        end else begin
            if (lap && m_st != 0) m_lap = m_cnt;
            if (clear) begin
                m_st = 0; m_pre = 0; m_cnt = 0;
            end else if (m_st == 1) begin
                if (stop) begin
                    m_st = 2;
                end else if (m_pre == TD - 1) begin
                    m_pre = 0;
                    m_cnt = (m_cnt + 1) % 10000;
                    if (lim_val(limit) == m_cnt) m_st = 3;
                end else begin
                    m_pre++;
                end
            end else if ((m_st == 0 || m_st == 2) && start && !stop) begin
                m_st = 1;
            end
        end
    endtask

    // One clock: predict, push, clock, pop, compare.
    task automatic step();
        exp_t e;
        model_next();
        e.d  = to_bcd(m_cnt);
        e.l  = to_bcd(m_lap);
        e.r  = (m_st == 1);
        e.dn = (m_st == 3);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_digits",  digits,           e.d);
        chk("sb_lap",     lap_digits,       e.l);
        chk("sb_running", {15'd0, running}, {15'd0, e.r});
        chk("sb_done",    {15'd0, done},    {15'd0, e.dn});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        int g;
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        limit = 16'h0000;

        // Reset and synchronised release
        steps(3);
        rst = 1'b1;
        steps(2);
        chk("rst_digits",  digits,     16'h0000);
        chk("rst_lap",     lap_digits, 16'h0000);
        chk("rst_running", {15'd0, running}, 16'h0000);
        chk("rst_done",    {15'd0, done},    16'h0000);
        $display("[%0t] txn reset: digits=%h running=%b done=%b", $time, digits, running, done);

        // Free run: 40 edges after the start edge
        pulse_start();
        steps(40);
        chk("run40_digits",  digits,           16'h0020);
        chk("run40_running", {15'd0, running}, 16'h0001);
        chk("run40_done",    {15'd0, done},    16'h0000);
        $display("[%0t] txn run40: digits=%h", $time, digits);

        // Limit reached 30 edges after start
        clear = 1'b1; step(); clear = 1'b0;
        limit = 16'h0015;
        pulse_start();
        steps(29);
        chk("lim_early_done", {15'd0, done}, 16'h0000);
        step();
        chk("lim_digits",  digits,           16'h0015);
        chk("lim_done",    {15'd0, done},    16'h0001);
        chk("lim_running", {15'd0, running}, 16'h0000);
        start = 1'b1; steps(3); start = 1'b0;
        chk("done_start_ignored", digits, 16'h0015);
        chk("done_hold",          {15'd0, done}, 16'h0001);
        clear = 1'b1; step(); clear = 1'b0;
        chk("done_clear_digits", digits,        16'h0000);
        chk("done_clear_done",   {15'd0, done}, 16'h0000);
        $display("[%0t] txn limit: done cleared, digits=%h", $time, digits);

        // Stop on a tick edge, hold, resume with the remaining interval
        limit = 16'h0000;
        pulse_start();
        g = 0;
        while (!(m_cnt == 7 && m_pre == TD - 1) && g < 200) begin step(); g++; end
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_tick_digits",  digits,           16'h0007);
        chk("stop_tick_running", {15'd0, running}, 16'h0000);
        steps(10);
        chk("pause_hold", digits, 16'h0007);
        pulse_start();
        chk("resume_digits",  digits,           16'h0007);
        chk("resume_running", {15'd0, running}, 16'h0001);
        step();
        chk("resume_tick", digits, 16'h0008);
        $display("[%0t] txn pause/resume: digits=%h", $time, digits);

        // Lap, then clear + lap together
        g = 0;
        while (m_cnt != 42 && g < 200) begin step(); g++; end
        chk("reach_42", digits, 16'h0042);
        lap = 1'b1; step(); lap = 1'b0;
        chk("lap_42", lap_digits, 16'h0042);
        g = 0;
        while (m_cnt != 50 && g < 200) begin step(); g++; end
        chk("reach_50", digits, 16'h0050);
        clear = 1'b1; lap = 1'b1; step(); clear = 1'b0; lap = 1'b0;
        chk("lap_50",       lap_digits, 16'h0050);
        chk("clrlap_digits", digits,    16'h0000);
        $display("[%0t] txn lap: lap_digits=%h", $time, lap_digits);

        // Ripple carry 0999 -> 1000 and wrap 9999 -> 0000
        pulse_start();
        g = 0;
        while (m_cnt != 999 && g < 3000) begin step(); g++; end
        chk("reach_0999", digits, 16'h0999);
        g = 0;
        while (m_cnt == 999 && g < 10) begin step(); g++; end
        chk("carry_1000", digits, 16'h1000);
        g = 0;
        while (m_cnt != 9999 && g < 25000) begin step(); g++; end
        chk("reach_9999", digits, 16'h9999);
        g = 0;
        while (m_cnt == 9999 && g < 10) begin step(); g++; end
        chk("wrap_0000", digits,           16'h0000);
        chk("wrap_run",  {15'd0, running}, 16'h0001);
        $display("[%0t] txn ripple: digits=%h", $time, digits);

        // Asynchronous reset between edges mid-run
        lap = 1'b1; step(); lap = 1'b0;
        steps(5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_digits",  digits,           16'h0000);
        chk("arst_lap",     lap_digits,       16'h0000);
        chk("arst_running", {15'd0, running}, 16'h0000);
        chk("arst_done",    {15'd0, done},    16'h0000);
        model_reset();
        steps(2);
        rst = 1'b1;
        steps(12);
        chk("post_rst_idle",    digits,           16'h0000);
        chk("post_rst_running", {15'd0, running}, 16'h0000);
        pulse_start();
        steps(6);
        chk("post_rst_count", digits, 16'h0003);
        $display("[%0t] txn async reset: digits=%h", $time, digits);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
